// File: rtl/alu_pipe.sv
// alu_pipe: registered execute-stage ALU with valid/ready handshakes, staged
// flags and an iterative shift-add multiplier.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   flush               synchronous kill of in-flight MUL and pending result
//   in_valid/in_ready   operation handshake (in_ready is combinational)
//   exec_command        4-bit opcode
//   set_flags           commit N/Z/C/V when this op's result is handed off
//   in1, in2            operands
//   out_valid/out_ready result handshake
//   result              registered result
//   status_n/z/c/v      committed flags
module alu_pipe #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_BITS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       exec_command,
  input  logic             set_flags,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             status_n,
  output logic             status_z,
  output logic             status_c,
  output logic             status_v
);

  localparam int unsigned MulSteps = WIDTH / MUL_BITS;
  localparam int unsigned CntW     = $clog2(MulSteps + 1);

  localparam logic [3:0] OpMov = 4'b0001;
  localparam logic [3:0] OpAdd = 4'b0010;
  localparam logic [3:0] OpAdc = 4'b0011;
  localparam logic [3:0] OpSub = 4'b0100;
  localparam logic [3:0] OpSbc = 4'b0101;
  localparam logic [3:0] OpAnd = 4'b0110;
  localparam logic [3:0] OpOrr = 4'b0111;
  localparam logic [3:0] OpEor = 4'b1000;
  localparam logic [3:0] OpMvn = 4'b1001;
  localparam logic [3:0] OpMul = 4'b1010;

  typedef enum logic [0:0] {StIdle, StMulBusy} state_e;

  state_e           state_q, state_d;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             stg_n_q, stg_z_q, stg_c_q, stg_v_q;
  logic             stg_cv_q;   // staged op updates C/V (arithmetic only)
  logic             stg_set_q;  // staged op commits flags on handoff
  logic             st_n_q, st_z_q, st_c_q, st_v_q;
  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q;
  logic [CntW-1:0]  mul_cnt_q;
  logic             mul_set_q;

  logic             handshake, out_free, accept, start_mul, load_alu, load_mul, mul_done;
  logic             fwd_c, is_sub, cin;
  logic [WIDTH-1:0] b_op, alu_res, mul_sum;
  logic [WIDTH:0]   sum;
  logic             alu_c, alu_v, alu_cv;

  assign handshake = out_valid_q && out_ready && !flush;
  assign out_free  = !out_valid_q || out_ready;
  assign in_ready  = (state_q == StIdle) && !flush && out_free;
  assign accept    = in_valid && in_ready;
  assign start_mul = accept && (exec_command == OpMul);
  assign load_alu  = accept && (exec_command != OpMul);
  assign mul_done  = (mul_cnt_q == CntW'(MulSteps));
  assign load_mul  = (state_q == StMulBusy) && mul_done && out_free && !flush;

  // A carry committed by this cycle's handoff is already visible to ADC/SBC.
  assign fwd_c = (handshake && stg_set_q && stg_cv_q) ? stg_c_q : st_c_q;

  always_comb begin
    is_sub = (exec_command == OpSub) || (exec_command == OpSbc);
    b_op   = is_sub ? ~in2 : in2;
    case (exec_command)
      OpAdc, OpSbc: cin = fwd_c;
      OpSub:        cin = 1'b1;
      default:      cin = 1'b0;
    endcase
    sum     = {1'b0, in1} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
    alu_c   = sum[WIDTH];
    alu_v   = (in1[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
    alu_cv  = 1'b0;
    alu_res = in1;
    case (exec_command)
      OpMov: alu_res = in2;
      OpMvn: alu_res = ~in2;
      OpAdd, OpAdc, OpSub, OpSbc: begin
        alu_res = sum[WIDTH-1:0];
        alu_cv  = 1'b1;
      end
      OpAnd: alu_res = in1 & in2;
      OpOrr: alu_res = in1 | in2;
      OpEor: alu_res = in1 ^ in2;
      default: alu_res = in1;
    endcase
  end

  // One iteration retires the low MUL_BITS multiplier bits.
  always_comb begin
    mul_sum = acc_q;
    for (int unsigned i = 0; i < MUL_BITS; i++) begin
      if (mplier_q[i]) mul_sum = mul_sum + (mcand_q << i);
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:    if (start_mul) state_d = StMulBusy;
        StMulBusy: if (mul_done && out_free) state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      stg_n_q     <= 1'b0;
      stg_z_q     <= 1'b0;
      stg_c_q     <= 1'b0;
      stg_v_q     <= 1'b0;
      stg_cv_q    <= 1'b0;
      stg_set_q   <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      stg_set_q   <= 1'b0;
    end else if (load_alu) begin
      out_valid_q <= 1'b1;
      result_q    <= alu_res;
      stg_n_q     <= alu_res[WIDTH-1];
      stg_z_q     <= (alu_res == '0);
      stg_c_q     <= alu_c;
      stg_v_q     <= alu_v;
      stg_cv_q    <= alu_cv;
      stg_set_q   <= set_flags;
    end else if (load_mul) begin
      out_valid_q <= 1'b1;
      result_q    <= acc_q;
      stg_n_q     <= acc_q[WIDTH-1];
      stg_z_q     <= (acc_q == '0);
      stg_cv_q    <= 1'b0;
      stg_set_q   <= mul_set_q;
    end else if (handshake) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_n_q <= 1'b0;
      st_z_q <= 1'b0;
      st_c_q <= 1'b0;
      st_v_q <= 1'b0;
    end else if (handshake && stg_set_q) begin
      st_n_q <= stg_n_q;
      st_z_q <= stg_z_q;
      if (stg_cv_q) begin
        st_c_q <= stg_c_q;
        st_v_q <= stg_v_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      mul_cnt_q <= '0;
      mul_set_q <= 1'b0;
    end else if (start_mul) begin
      mcand_q   <= in1;
      mplier_q  <= in2;
      acc_q     <= '0;
      mul_cnt_q <= '0;
      mul_set_q <= set_flags;
    end else if ((state_q == StMulBusy) && !mul_done && !flush) begin
      acc_q     <= mul_sum;
      mcand_q   <= mcand_q << MUL_BITS;
      mplier_q  <= mplier_q >> MUL_BITS;
      mul_cnt_q <= mul_cnt_q + CntW'(1);
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign status_n  = st_n_q;
  assign status_z  = st_z_q;
  assign status_c  = st_c_q;
  assign status_v  = st_v_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: vector table, hand-written corner sequences and a randomized
// run against a cycle-level reference model for alu_pipe (WIDTH=32).
module tb_alu_pipe;

  localparam int unsigned W = 32;

  localparam logic [3:0] OpMov = 4'b0001, OpAdd = 4'b0010, OpAdc = 4'b0011;
  localparam logic [3:0] OpSub = 4'b0100, OpSbc = 4'b0101, OpAnd = 4'b0110;
  localparam logic [3:0] OpOrr = 4'b0111, OpEor = 4'b1000, OpMvn = 4'b1001;
  localparam logic [3:0] OpMul = 4'b1010, OpPass = 4'b1111, OpZero = 4'b0000;

  localparam longint MaxS = 64'sd2147483647;
  localparam longint MinS = -64'sd2147483648;

  logic         clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0;
  logic         set_flags = 1'b0, out_ready = 1'b0;
  logic [3:0]   exec_command = 4'b0;
  logic [W-1:0] in1 = '0, in2 = '0;

  logic         in_ready, out_valid, status_n, status_z, status_c, status_v;
  logic [W-1:0] result;
  logic         in_ready4, out_valid4, status_n4, status_z4, status_c4, status_v4;
  logic [W-1:0] result4;

  alu_pipe #(.WIDTH(32), .MUL_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .exec_command(exec_command), .set_flags(set_flags), .in1(in1), .in2(in2),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .status_n(status_n), .status_z(status_z), .status_c(status_c), .status_v(status_v)
  );

  alu_pipe #(.WIDTH(32), .MUL_BITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
    .exec_command(exec_command), .set_flags(set_flags), .in1(in1), .in2(in2),
    .out_valid(out_valid4), .out_ready(out_ready), .result(result4),
    .status_n(status_n4), .status_z(status_z4), .status_c(status_c4), .status_v(status_v4)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input logic [W-1:0] act,
                                input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [3:0] st1();
    return {status_n, status_z, status_c, status_v};
  endfunction

  function automatic logic [3:0] st4();
    return {status_n4, status_z4, status_c4, status_v4};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] cmd, input logic sf, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    in_valid     = 1'b1;
    exec_command = cmd;
    set_flags    = sf;
    in1          = a;
    in2          = b;
  endtask

  // Offer one op and let the edge accept it; ends at the following negedge.
  task automatic send(input logic [3:0] cmd, input logic sf, input logic [W-1:0] a,
                      input logic [W-1:0] b);
    drive(cmd, sf, a, b);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    flush    = 1'b0;
    rst_n    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Reference ALU computed from the arithmetic definitions.
  function automatic void ref_op(input logic [3:0] cmd, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic c_in,
                                 output logic [W-1:0] r, output logic c, output logic v,
                                 output logic cv);
    longint      sa, sb, sr, bw;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = a;
    c  = 1'b0;
    v  = 1'b0;
    cv = 1'b0;
    case (cmd)
      OpMov: r = b;
      OpMvn: r = ~b;
      OpAnd: r = a & b;
      OpOrr: r = a | b;
      OpEor: r = a ^ b;
      OpMul: begin
        u = 64'(a) * 64'(b);
        r = u[31:0];
      end
      OpAdd, OpAdc: begin
        bw = (cmd == OpAdc && c_in) ? 64'sd1 : 64'sd0;
        u  = 64'(a) + 64'(b) + 64'(bw);
        r  = u[31:0];
        c  = u[32];
        sr = sa + sb + bw;
        v  = (sr > MaxS) || (sr < MinS);
        cv = 1'b1;
      end
      OpSub, OpSbc: begin
        bw = (cmd == OpSbc && !c_in) ? 64'sd1 : 64'sd0;
        r  = a - b - 32'(bw);
        c  = (64'(a) >= 64'(b) + 64'(bw));
        sr = sa - sb - bw;
        v  = (sr > MaxS) || (sr < MinS);
        cv = 1'b1;
      end
      default: r = a;
    endcase
  endfunction

  typedef struct {
    logic [3:0]   cmd;
    logic         sf;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_res;
    logic [3:0]   exp_st;  // {N,Z,C,V} after the handoff
  } vec_t;

  localparam int NVec = 18;
  vec_t vecs[NVec];

  task automatic do_vec(input vec_t t, input int idx);
    int cnt;
    out_ready = 1'b1;
    drive(t.cmd, t.sf, t.a, t.b);
    #1 check($sformatf("vec%0d_in_ready", idx), W'(in_ready), W'(1));
    tick();
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      tick();
      cnt++;
    end
    check($sformatf("vec%0d_latency", idx), W'(cnt), (t.cmd == OpMul) ? W'(33) : W'(0));
    check($sformatf("vec%0d_result", idx), result, t.exp_res);
    tick();
    check($sformatf("vec%0d_status", idx), W'(st1()), W'(t.exp_st));
  endtask

  // Cycle-level model state for the random run.
  logic         m_ov, m_mul_set, m_stg_n, m_stg_z, m_stg_c, m_stg_v, m_stg_cv, m_stg_set;
  logic [W-1:0] m_res, m_mul_res;
  logic [3:0]   m_st;
  int           m_busy;

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic         saw, exp_ready, hs, acc_op, rc, rv, rcv;
    logic [W-1:0] rr;
    logic [3:0]   cmd;
    int           t1, t4;

    vecs[0]  = '{OpAdd,  1'b1, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 4'b1001};
    vecs[1]  = '{OpMov,  1'b1, 32'hDEAD_BEEF, 32'h0,         32'h0,         4'b0101};
    vecs[2]  = '{OpSub,  1'b1, 32'h5,         32'h5,         32'h0,         4'b0110};
    vecs[3]  = '{OpEor,  1'b1, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 32'hF0F0_F0F0, 4'b1010};
    vecs[4]  = '{OpSbc,  1'b1, 32'h0,         32'h0,         32'h0,         4'b0110};
    vecs[5]  = '{OpAdd,  1'b1, 32'h0,         32'h0,         32'h0,         4'b0100};
    vecs[6]  = '{OpSbc,  1'b1, 32'h0,         32'h0,         32'hFFFF_FFFF, 4'b1000};
    vecs[7]  = '{OpAdc,  1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0,         4'b0111};
    vecs[8]  = '{OpAdc,  1'b1, 32'h1,         32'h1,         32'h3,         4'b0000};
    vecs[9]  = '{OpMvn,  1'b1, 32'h1234,      32'h0,         32'hFFFF_FFFF, 4'b1000};
    vecs[10] = '{OpOrr,  1'b1, 32'h1,         32'h100,       32'h101,       4'b0000};
    vecs[11] = '{OpPass, 1'b1, 32'h1234_5678, 32'h9,         32'h1234_5678, 4'b0000};
    vecs[12] = '{OpSub,  1'b1, 32'h0,         32'h1,         32'hFFFF_FFFF, 4'b1000};
    vecs[13] = '{OpAdd,  1'b0, 32'h1,         32'h1,         32'h2,         4'b1000};
    vecs[14] = '{OpSub,  1'b1, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 4'b0011};
    vecs[15] = '{OpMul,  1'b1, 32'h3,         32'h5,         32'hF,         4'b0011};
    vecs[16] = '{OpAnd,  1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b1011};
    vecs[17] = '{OpZero, 1'b1, 32'h0,         32'h55,        32'h0,         4'b0111};

    // Reset state.
    @(negedge clk);
    #1;
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_result", result, W'(0));
    check("rst_status", W'(st1()), W'(0));
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", W'(in_ready), W'(1));

    for (int i = 0; i < NVec; i++) do_vec(vecs[i], i);

    // Carry forwarding: ADC accepted in the same cycle as the ADD's handoff.
    out_ready = 1'b1;
    send(OpAdd, 1'b1, 32'h0, 32'h0);
    tick();
    check("fwd_c_cleared", W'(status_c), W'(0));
    out_ready = 1'b0;
    send(OpAdd, 1'b1, 32'hFFFF_FFFF, 32'h1);
    check("fwd_add_result", result, W'(0));
    out_ready = 1'b1;
    drive(OpAdc, 1'b1, 32'h0, 32'h0);
    #1 check("fwd_in_ready", W'(in_ready), W'(1));
    check("fwd_c_not_yet", W'(status_c), W'(0));
    tick();
    in_valid = 1'b0;
    check("fwd_adc_result", result, W'(1));
    check("fwd_c_committed", W'(status_c), W'(1));
    tick();
    check("fwd_adc_status", W'(st1()), W'(4'b0000));

    // Output stall: result and flags hold, nothing accepted.
    out_ready = 1'b0;
    send(OpEor, 1'b1, 32'hFFFF_FFFF, 32'h0);
    for (int i = 0; i < 5; i++) begin
      drive(OpAdd, 1'b1, 32'h1, 32'h1);
      #1;
      check("stall_in_ready", W'(in_ready), W'(0));
      check("stall_out_valid", W'(out_valid), W'(1));
      check("stall_result", result, 32'hFFFF_FFFF);
      check("stall_status", W'(st1()), W'(4'b0000));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("stall_release_status", W'(st1()), W'(4'b1000));

    // MUL latency at MUL_BITS=1 and 4; C/V must survive.
    do_reset();
    out_ready = 1'b1;
    send(OpSub, 1'b1, 32'h8000_0000, 32'h1);
    tick();
    check("mul_pre_status", W'(st1()), W'(4'b0011));
    out_ready = 1'b0;
    send(OpMul, 1'b1, 32'h0001_0000, 32'h0001_0000);
    t1 = -1;
    t4 = -1;
    saw = 1'b0;
    for (int cnt = 0; cnt < 40; cnt++) begin
      if (out_valid && t1 < 0) t1 = cnt;
      if (out_valid4 && t4 < 0) t4 = cnt;
      saw = saw | in_ready;
      tick();
    end
    check("mul1_latency", W'(t1), W'(33));
    check("mul4_latency", W'(t4), W'(9));
    check("mul_in_ready_low", W'(saw), W'(0));
    check("mul1_result", result, W'(0));
    check("mul4_result", result4, W'(0));
    out_ready = 1'b1;
    tick();
    check("mul1_status", W'(st1()), W'(4'b0111));
    check("mul4_status", W'(st4()), W'(4'b0111));

    // Flush at cycle 10 of a MUL.
    send(OpMul, 1'b1, 32'h3, 32'h5);
    repeat (9) tick();
    flush = 1'b1;
    #1 check("flush_in_ready", W'(in_ready), W'(0));
    tick();
    flush = 1'b0;
    #1 check("flush_ready_after", W'(in_ready), W'(1));
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      saw = saw | out_valid;
      tick();
    end
    check("flush_no_valid", W'(saw), W'(0));
    check("flush_status", W'(st1()), W'(4'b0111));

    // Handoff coinciding with flush must not commit.
    out_ready = 1'b0;
    send(OpAdd, 1'b1, 32'hFFFF_FFFF, 32'h0);
    check("flush_hs_pending", W'(out_valid), W'(1));
    flush     = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_hs_valid", W'(out_valid), W'(0));
    tick();
    check("flush_hs_status", W'(st1()), W'(4'b0111));

    // Asynchronous reset in the middle of a MUL.
    send(OpMul, 1'b1, 32'h3, 32'h5);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    check("amid_out_valid", W'(out_valid), W'(0));
    check("amid_result", result, W'(0));
    check("amid_status", W'(st1()), W'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("amid_in_ready", W'(in_ready), W'(1));
    send(OpAdd, 1'b1, 32'h2, 32'h3);
    check("amid_add_valid", W'(out_valid), W'(1));
    check("amid_add_result", result, W'(5));

    // Randomized run against the cycle model.
    do_reset();
    m_ov = 1'b0; m_res = '0; m_st = 4'b0; m_busy = 0; m_mul_res = '0; m_mul_set = 1'b0;
    m_stg_n = 1'b0; m_stg_z = 1'b0; m_stg_c = 1'b0; m_stg_v = 1'b0;
    m_stg_cv = 1'b0; m_stg_set = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      cmd = 4'($urandom_range(0, 15));
      if (cmd == OpMul && $urandom_range(0, 3) != 0) cmd = OpAdc;
      in_valid     = ($urandom_range(0, 3) != 0);
      exec_command = cmd;
      set_flags    = ($urandom_range(0, 3) != 0);
      in1          = pick();
      in2          = pick();
      out_ready    = ($urandom_range(0, 3) != 0);
      flush        = ($urandom_range(0, 40) == 0);
      #1;
      exp_ready = !flush && (m_busy == 0) && (!m_ov || out_ready);
      check("rnd_in_ready", W'(in_ready), W'(exp_ready));
      check("rnd_out_valid", W'(out_valid), W'(m_ov));
      check("rnd_result", result, m_res);
      check("rnd_status", W'(st1()), W'(m_st));

      hs     = m_ov && out_ready && !flush;
      acc_op = in_valid && exp_ready;
      if (flush) begin
        m_ov      = 1'b0;
        m_busy    = 0;
        m_stg_set = 1'b0;
      end else begin
        if (hs && m_stg_set) begin
          m_st[3] = m_stg_n;
          m_st[2] = m_stg_z;
          if (m_stg_cv) begin
            m_st[1] = m_stg_c;
            m_st[0] = m_stg_v;
          end
        end
        if (acc_op && cmd == OpMul) begin
          ref_op(cmd, in1, in2, m_st[1], m_mul_res, rc, rv, rcv);
          m_mul_set = set_flags;
          m_busy    = W + 1;
          if (hs) m_ov = 1'b0;
        end else if (acc_op) begin
          ref_op(cmd, in1, in2, m_st[1], rr, rc, rv, rcv);
          m_ov = 1'b1; m_res = rr;
          m_stg_n = rr[W-1]; m_stg_z = (rr == 0); m_stg_c = rc; m_stg_v = rv;
          m_stg_cv = rcv; m_stg_set = set_flags;
        end else if (m_busy == 1 && (!m_ov || out_ready)) begin
          m_busy = 0;
          m_ov = 1'b1; m_res = m_mul_res;
          m_stg_n = m_mul_res[W-1]; m_stg_z = (m_mul_res == 0);
          m_stg_cv = 1'b0; m_stg_set = m_mul_set;
        end else begin
          if (m_busy > 1) m_busy--;
          if (hs) m_ov = 1'b0;
        end
      end
      tick();
    end
    in_valid = 1'b0;
    flush    = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
